// File: rtl/ctl_round.sv
// Duck-hunt round controller: sequences intro, duck flights, results and round advance/game over.
// All outputs registered (one cycle after the causing input); pause freezes state, no backpressure.
module ctl_round #(
    parameter int DUCKS_PER_ROUND = 10,
    parameter int SHOTS_PER_DUCK  = 3,
    parameter int PASS_HITS       = 6,
    parameter int INTRO_FRAMES    = 120,
    parameter int RESULT_FRAMES   = 60,
    parameter int TIMEOUT_FRAMES  = 300,
    parameter int SPD_W           = 5,
    parameter int BASE_SPEED      = 10,
    parameter int SPEED_STEP      = 1,
    parameter int MAX_ROUND       = 99
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  new_frame,
    input  logic                                  start,
    input  logic                                  pause,
    input  logic                                  hit,
    input  logic                                  shot_fired,
    output logic                                  duck_respawn,
    output logic                                  duck_active,
    output logic                                  round_intro,
    output logic                                  game_over,
    output logic                                  no_ammo,
    output logic [$clog2(SHOTS_PER_DUCK+1)-1:0]   shots_left,
    output logic [$clog2(DUCKS_PER_ROUND+1)-1:0]  hits,
    output logic [6:0]                            round_num,
    output logic [SPD_W-1:0]                      h_speed
);

    localparam int SW   = $clog2(SHOTS_PER_DUCK + 1);
    localparam int HW   = $clog2(DUCKS_PER_ROUND + 1);
    localparam int FMAX0 = (INTRO_FRAMES > RESULT_FRAMES) ? INTRO_FRAMES : RESULT_FRAMES;
    localparam int FMAX  = (FMAX0 > TIMEOUT_FRAMES) ? FMAX0 : TIMEOUT_FRAMES;
    localparam int FW   = $clog2(FMAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        INTRO,
        FLY,
        RESULT,
        ROUND_END,
        OVER
    } state_t;

    state_t          state, state_nxt;
    logic [FW-1:0]   frame_cnt, frame_nxt;
    logic [HW-1:0]   duck_cnt, duck_nxt, duck_inc;
    logic [SW-1:0]   shots_nxt;
    logic [HW-1:0]   hits_nxt;
    logic [6:0]      round_nxt;
    logic [SPD_W-1:0] speed_nxt;
    logic [SPD_W:0]  speed_sum;
    logic            respawn_nxt;
    logic            shot_ok;

    always_comb begin
        state_nxt   = state;
        frame_nxt   = frame_cnt;
        duck_nxt    = duck_cnt;
        shots_nxt   = shots_left;
        hits_nxt    = hits;
        round_nxt   = round_num;
        speed_nxt   = h_speed;
        respawn_nxt = 1'b0;
        duck_inc    = duck_cnt + HW'(1);
        speed_sum   = {1'b0, h_speed} + (SPD_W+1)'(SPEED_STEP);
        shot_ok     = shot_fired && (shots_left != '0);

        // Pause freezes everything, including the start pulse in IDLE/OVER.
        if (!pause) begin
            case (state)
                IDLE, OVER: begin
                    if (start) begin
                        state_nxt = INTRO;
                        round_nxt = 7'd1;
                        speed_nxt = SPD_W'(BASE_SPEED);
                        hits_nxt  = '0;
                        duck_nxt  = '0;
                        frame_nxt = '0;
                    end
                end
                INTRO: begin
                    if (new_frame) begin
                        if (frame_cnt == FW'(INTRO_FRAMES - 1)) begin
                            state_nxt   = FLY;
                            respawn_nxt = 1'b1;
                            shots_nxt   = SW'(SHOTS_PER_DUCK);
                            frame_nxt   = '0;
                        end else begin
                            frame_nxt = frame_cnt + FW'(1);
                        end
                    end
                end
                FLY: begin
                    if (shot_ok)
                        shots_nxt = shots_left - SW'(1);
                    // A hit wins over escape; an empty magazine escapes the cycle after it empties.
                    if (hit) begin
                        hits_nxt  = hits + HW'(1);
                        state_nxt = RESULT;
                        frame_nxt = '0;
                    end else if (shots_left == '0) begin
                        state_nxt = RESULT;
                        frame_nxt = '0;
                    end else if (new_frame) begin
                        if (frame_cnt == FW'(TIMEOUT_FRAMES - 1)) begin
                            state_nxt = RESULT;
                            frame_nxt = '0;
                        end else begin
                            frame_nxt = frame_cnt + FW'(1);
                        end
                    end
                end
                RESULT: begin
                    if (new_frame) begin
                        if (frame_cnt == FW'(RESULT_FRAMES - 1)) begin
                            frame_nxt = '0;
                            duck_nxt  = duck_inc;
                            if (duck_inc == HW'(DUCKS_PER_ROUND)) begin
                                state_nxt = ROUND_END;
                            end else begin
                                state_nxt   = FLY;
                                respawn_nxt = 1'b1;
                                shots_nxt   = SW'(SHOTS_PER_DUCK);
                            end
                        end else begin
                            frame_nxt = frame_cnt + FW'(1);
                        end
                    end
                end
                ROUND_END: begin
                    if (hits >= HW'(PASS_HITS)) begin
                        state_nxt = INTRO;
                        round_nxt = (round_num >= 7'(MAX_ROUND)) ? round_num : round_num + 7'd1;
                        speed_nxt = speed_sum[SPD_W] ? {SPD_W{1'b1}} : speed_sum[SPD_W-1:0];
                        hits_nxt  = '0;
                        duck_nxt  = '0;
                        frame_nxt = '0;
                    end else begin
                        state_nxt = OVER;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            frame_cnt    <= '0;
            duck_cnt     <= '0;
            shots_left   <= '0;
            hits         <= '0;
            round_num    <= '0;
            h_speed      <= SPD_W'(BASE_SPEED);
            duck_respawn <= 1'b0;
            duck_active  <= 1'b0;
            round_intro  <= 1'b0;
            game_over    <= 1'b0;
            no_ammo      <= 1'b0;
        end else begin
            state        <= state_nxt;
            frame_cnt    <= frame_nxt;
            duck_cnt     <= duck_nxt;
            shots_left   <= shots_nxt;
            hits         <= hits_nxt;
            round_num    <= round_nxt;
            h_speed      <= speed_nxt;
            duck_respawn <= respawn_nxt;
            duck_active  <= (state_nxt == FLY);
            round_intro  <= (state_nxt == INTRO);
            game_over    <= (state_nxt == OVER);
            no_ammo      <= (state_nxt == FLY) && (shots_nxt == '0);
        end
    end

endmodule
